// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C requester arbiter: mode codes, field widths,
// FSM state encoding and the mode legality helper.
package i2c_pkg;

  localparam int MODE_W = 8;
  localparam int DEV_W  = 7;
  localparam int REG_W  = 8;
  localparam int DATA_W = 8;

  localparam logic [MODE_W-1:0] I2C_WAIT         = 8'h00;
  localparam logic [MODE_W-1:0] I2C_WRITE_REG    = 8'h01;
  localparam logic [MODE_W-1:0] I2C_READ_REG     = 8'h02;
  localparam logic [MODE_W-1:0] I2C_WRITE_BYTE   = 8'h03;
  localparam logic [MODE_W-1:0] I2C_READ_BYTE    = 8'h04;
  localparam logic [MODE_W-1:0] I2C_WRITE_DIRECT = 8'h05;
  localparam logic [MODE_W-1:0] I2C_READ_DIRECT  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  // I2C_WAIT is a master-internal code, so a requester may only ask for 0x01..0x06.
  function automatic logic mode_legal(input logic [MODE_W-1:0] mode);
    return (mode >= I2C_WRITE_REG) && (mode <= I2C_READ_DIRECT);
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after rr_ptr,
// wrapping around, returned as one-hot, index and valid.
module i2c_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  localparam int PW = IDX_W + 1;
  localparam logic [PW-1:0] NUM_L = PW'(NUM_REQ);

  logic [PW-1:0] pos;

  // Scan from the farthest offset down so the closest request to rr_ptr wins last.
  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = |req;
    pos        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + PW'(k);
      if (pos >= NUM_L) pos = pos - NUM_L;
      if (req[pos[IDX_W-1:0]]) pick_idx = pos[IDX_W-1:0];
    end
    if (pick_valid) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master core between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic                        clk_12m,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [MODE_W*NUM_REQ-1:0]   req_mode,
  input  logic [DEV_W*NUM_REQ-1:0]    req_dev_addr,
  input  logic [REG_W*NUM_REQ-1:0]    req_reg_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        err,
  output logic                        mst_start,
  output logic [MODE_W-1:0]           mst_config,
  output logic [DEV_W-1:0]            mst_dev_addr,
  output logic [REG_W-1:0]            mst_reg_addr,
  output logic [DATA_W-1:0]           mst_wdata,
  input  logic                        mst_done,
  input  logic                        mst_nack,
  input  logic [DATA_W-1:0]           mst_rdata,
  output arb_state_e                  dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("i2c_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr, win_idx, pick_idx;
  logic [NUM_REQ-1:0] win_oh, pick_oh;
  logic               pick_valid, err_q, timeout_hit;
  logic [DATA_W-1:0]  rdata_q;

  logic [MODE_W-1:0]  mode_a [NUM_REQ];
  logic [DEV_W-1:0]   dev_a  [NUM_REQ];
  logic [REG_W-1:0]   reg_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdat_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign mode_a[i] = req_mode[MODE_W*i +: MODE_W];
    assign dev_a[i]  = req_dev_addr[DEV_W*i +: DEV_W];
    assign reg_a[i]  = req_reg_addr[REG_W*i +: REG_W];
    assign wdat_a[i] = req_wdata[DATA_W*i +: DATA_W];
  end

  i2c_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk_12m) begin
    if (rst || state_q != ST_WAIT) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_LATCH;
      ST_LATCH: state_d = mode_legal(mst_config) ? ST_START : ST_DONE;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (mst_done || timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Requests are sampled only in IDLE; later requester activity cannot disturb the latched transaction.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr       <= '0;
      win_idx      <= '0;
      win_oh       <= '0;
      mst_config   <= '0;
      mst_dev_addr <= '0;
      mst_reg_addr <= '0;
      mst_wdata    <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            win_idx      <= pick_idx;
            win_oh       <= pick_oh;
            mst_config   <= mode_a[pick_idx];
            mst_dev_addr <= dev_a[pick_idx];
            mst_reg_addr <= reg_a[pick_idx];
            mst_wdata    <= wdat_a[pick_idx];
          end
        end
        ST_LATCH: begin
          if (!mode_legal(mst_config)) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_WAIT: begin
          if (mst_done) begin
            rdata_q <= mst_rdata;
            err_q   <= mst_nack;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = (state_q == ST_LATCH || state_q == ST_START || state_q == ST_WAIT) ? win_oh : '0;
  assign done      = (state_q == ST_DONE) ? win_oh : '0;
  assign err       = (state_q == ST_DONE) && err_q;
  assign mst_start = (state_q == ST_START);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: directed cases plus randomized
// request traffic compared against a transaction-level round-robin model.
module tb_i2c_req_arbiter;
  import i2c_pkg::*;

  localparam int N  = 4;
  localparam int TO = 100;

  logic              clk_12m = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [8*N-1:0]    req_mode;
  logic [7*N-1:0]    req_dev_addr;
  logic [8*N-1:0]    req_reg_addr;
  logic [8*N-1:0]    req_wdata;
  logic [N-1:0]      gnt, done;
  logic [7:0]        rdata;
  logic              err, mst_start;
  logic [7:0]        mst_config, mst_reg_addr, mst_wdata;
  logic [6:0]        mst_dev_addr;
  logic              mst_done, mst_nack;
  logic [7:0]        mst_rdata;
  arb_state_e        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk_12m = ~clk_12m;

  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_12m(clk_12m), .rst(rst), .req(req), .req_mode(req_mode),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .mst_start(mst_start),
    .mst_config(mst_config), .mst_dev_addr(mst_dev_addr), .mst_reg_addr(mst_reg_addr),
    .mst_wdata(mst_wdata), .mst_done(mst_done), .mst_nack(mst_nack),
    .mst_rdata(mst_rdata), .dbg_state(dbg_state)
  );

  // ---------------- requester model state ----------------
  logic [7:0]   m_mode [N];
  logic [6:0]   m_dev  [N];
  logic [7:0]   m_reg  [N];
  logic [7:0]   m_wdat [N];
  logic [N-1:0] pending;
  int           rr;
  int           waits [N];
  logic         fr_en, fr_nack;
  logic [7:0]   fr_rd;
  int           n_tests = 0;
  int           n_fail  = 0;

  always_comb begin
    req          = pending;
    req_mode     = '0;
    req_dev_addr = '0;
    req_reg_addr = '0;
    req_wdata    = '0;
    for (int i = 0; i < N; i++) begin
      req_mode[8*i +: 8]     = m_mode[i];
      req_dev_addr[7*i +: 7] = m_dev[i];
      req_reg_addr[8*i +: 8] = m_reg[i];
      req_wdata[8*i +: 8]    = m_wdat[i];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Winner: first pending requester at or after the pointer, counting around the ring.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_fields(input int i);
    m_mode[i] = 8'($urandom_range(0, 8));
    m_dev[i]  = 7'($urandom);
    m_reg[i]  = 8'($urandom);
    m_wdat[i] = 8'($urandom);
  endtask

  task automatic set_pending(input logic [N-1:0] v);
    pending = v;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  // Entered in an IDLE cycle with requests on the bus; returns in the next IDLE cycle.
  task automatic do_txn(input bit keep, output int w_obs);
    int         w, d;
    logic       legal, exp_nack;
    logic [7:0] exp_rd;
    w = model_pick(pending, rr);
    legal = (m_mode[w] >= 8'h01) && (m_mode[w] <= 8'h06);
    @(negedge clk_12m);
    w_obs = oh2idx(gnt);
    check("gnt_latch", gnt, N'(1) << w);
    check("cfg", mst_config, m_mode[w]);
    check("dev", mst_dev_addr, m_dev[w]);
    check("reg", mst_reg_addr, m_reg[w]);
    check("wdata", mst_wdata, m_wdat[w]);
    check("start_latch", mst_start, 0);
    if (legal) begin
      @(negedge clk_12m);
      check("start", mst_start, 1);
      check("gnt_start", gnt, N'(1) << w);
      if ($urandom_range(0, 1) == 1) begin
        mst_done  = 1'b1;
        mst_nack  = 1'b1;
        mst_rdata = 8'($urandom);
      end
      @(negedge clk_12m);
      mst_done = 1'b0;
      check("start_once", mst_start, 0);
      check("no_early_done", done, 0);
      check("hold_dev", mst_dev_addr, m_dev[w]);
      d = $urandom_range(0, 4);
      repeat (d) begin
        @(negedge clk_12m);
        check("wait_done", done, 0);
      end
      exp_rd   = fr_en ? fr_rd : 8'($urandom);
      exp_nack = fr_en ? fr_nack : 1'($urandom_range(0, 1));
      mst_rdata = exp_rd;
      mst_nack  = exp_nack;
      mst_done  = 1'b1;
      @(negedge clk_12m);
      mst_done  = 1'b0;
      mst_rdata = 8'($urandom);
      check("done", done, N'(1) << w);
      check("rdata", rdata, exp_rd);
      check("err", err, exp_nack);
      check("gnt_done", gnt, 0);
    end else begin
      @(negedge clk_12m);
      check("ill_done", done, N'(1) << w);
      check("ill_err", err, 1);
      check("ill_start", mst_start, 0);
      exp_rd = rdata;
    end
    if (w_obs >= 0) begin
      check("fair", waits[w_obs] <= N - 1, 1);
      for (int i = 0; i < N; i++) if (pending[i] && i != w_obs) waits[i]++;
      waits[w_obs] = 0;
    end
    rr = (w + 1) % N;
    if (!keep) begin
      logic [N-1:0] nw;
      pending[w] = 1'b0;
      nw = N'($urandom_range(0, (1 << N) - 1)) & ~pending;
      if ((pending | nw) == '0) nw = N'(1) << $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) if (nw[i]) begin
        rand_fields(i);
        waits[i] = 0;
      end
      pending = pending | nw;
    end
    @(negedge clk_12m);
    check("idle_done", done, 0);
    check("idle_gnt", gnt, 0);
    check("idle_err", err, 0);
    if (legal) check("rdata_hold", rdata, exp_rd);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int exp_order [4];
    int cnt;
    exp_order = '{0, 1, 3, 0};
    rst = 1'b1; mst_done = 1'b0; mst_nack = 1'b0; mst_rdata = '0;
    fr_en = 1'b0; fr_nack = 1'b0; fr_rd = '0; rr = 0;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = '0; m_dev[i] = '0; m_reg[i] = '0; m_wdat[i] = '0;
    end
    set_pending('0);
    repeat (3) @(negedge clk_12m);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_start", mst_start, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Single write from requester 0.
    m_mode[0] = 8'h01; m_dev[0] = 7'h50; m_reg[0] = 8'h00; m_wdat[0] = 8'h11;
    set_pending(4'b0001);
    rst = 1'b0;
    do_txn(1'b0, w);
    check("t1_winner", w, 0);

    // Reset in WAIT abandons the transaction.
    m_mode[0] = 8'h02;
    set_pending(4'b0001);
    repeat (3) @(negedge clk_12m);
    check("pre_rst_gnt", gnt, 4'b0001);
    rst = 1'b1;
    @(negedge clk_12m);
    check("wrst_gnt", gnt, 0);
    check("wrst_done", done, 0);
    check("wrst_err", err, 0);
    check("wrst_start", mst_start, 0);
    check("wrst_cfg", mst_config, 0);
    check("wrst_dev", mst_dev_addr, 0);
    check("wrst_reg", mst_reg_addr, 0);
    check("wrst_wdata", mst_wdata, 0);
    check("wrst_rdata", rdata, 0);
    check("wrst_state", dbg_state, ST_IDLE);
    rr = 0;
    for (int i = 0; i < N; i++) m_mode[i] = 8'($urandom_range(1, 6));
    set_pending(4'b1011);
    rst = 1'b0;

    // Held requests rotate 0,1,3,0.
    for (int k = 0; k < 4; k++) begin
      do_txn(1'b1, w);
      check("rr_order", w, exp_order[k]);
    end

    // Read from requester 2 with forced response.
    m_mode[2] = 8'h04;
    set_pending(4'b0100);
    fr_en = 1'b1; fr_rd = 8'hA5; fr_nack = 1'b0;
    do_txn(1'b0, w);
    fr_en = 1'b0;
    check("a5_rdata", rdata, 8'hA5);

    // Illegal mode from requester 1.
    m_mode[1] = 8'h07;
    set_pending(4'b0010);
    do_txn(1'b0, w);
    check("ill_winner", w, 1);

`ifdef I2C_ARB_TIMEOUT_EN
    m_mode[0] = 8'h01;
    set_pending(4'b0001);
    repeat (2) @(negedge clk_12m);
    check("to_start", mst_start, 1);
    cnt = 0;
    while (done == '0 && cnt < 3 * TO) begin
      @(negedge clk_12m);
      cnt++;
    end
    check("to_cycles", cnt, TO + 1);
    check("to_done", done, 4'b0001);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    rr = 1;
    set_pending('0);
    @(negedge clk_12m);
`endif
    cnt = 0;

    // Randomized traffic.
    for (int i = 0; i < N; i++) rand_fields(i);
    set_pending(N'($urandom_range(1, (1 << N) - 1)));
    repeat (150) do_txn(1'b0, w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
